// File: rtl/sid_audio_pkg.sv
// Shared widths, limits and mixing helpers for the SID/PSG audio mixer.
// Everything that must agree between the DC blocker and the mixer top lives here.
package sid_audio_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int YI_W          = SAMPLE_W + 2;  // integer part of filter output
  localparam int ACC_W         = SAMPLE_W + 3;  // scaled SID + PSG sum
  localparam int DEF_DCB_SHIFT = 10;
  localparam int DEF_FRAC      = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam acc_t SAT_MAX = acc_t'(32767);
  localparam acc_t SAT_MIN = acc_t'(-32768);

  // Scale filtered SID by (vol+1)/8 and add PSG; |y| <= 2^17 keeps this inside ACC_W.
  function automatic acc_t mix(input logic signed [YI_W-1:0] y,
                               input logic [2:0]             vol,
                               input sample_t                psg);
    logic signed [4:0]      gain;
    logic signed [YI_W+4:0] prod;
    gain = signed'(5'({2'b00, vol}) + 5'd1);
    prod = y * gain;
    return signed'(prod[ACC_W+2:3]) + acc_t'(psg);
  endfunction

  function automatic logic is_clip(input acc_t s);
    return (s > SAT_MAX) || (s < SAT_MIN);
  endfunction

  function automatic sample_t saturate(input acc_t s);
    if (s > SAT_MAX) return sample_t'(SAT_MAX);
    if (s < SAT_MIN) return sample_t'(SAT_MIN);
    return sample_t'(s);
  endfunction

endpackage

// File: rtl/sid_dc_block.sv
// One-channel DC blocker: y = x - x_prev + y_prev - (y_prev >>> DCB_SHIFT),
// evaluated at FRAC-extended precision; clr holds the filter state at zero.
module sid_dc_block
  import sid_audio_pkg::*;
#(
  parameter int DCB_SHIFT = DEF_DCB_SHIFT,
  parameter int FRAC      = DEF_FRAC
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clr,
  input  sample_t                x,
  output logic signed [YI_W-1:0] y_int
);

  localparam int W = SAMPLE_W + FRAC + 2;

  logic signed [W-1:0] x_ext, x_prev, y, y_next;

  assign x_ext  = W'(x) <<< FRAC;
  assign y_next = x_ext - x_prev + y - (y >>> DCB_SHIFT);
  assign y_int  = y[W-1:FRAC];

  // y doubles as y_prev: it only advances on an accepted sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_prev <= '0;
      y      <= '0;
    end else if (clr) begin
      x_prev <= '0;
      y      <= '0;
    end else if (en) begin
      x_prev <= x_ext;
      y      <= y_next;
    end
  end

endmodule

// File: rtl/sid_audio_mixer.sv
// Stereo SID + PSG mixer: offset-binary SID is DC-blocked, volume scaled,
// summed with signed PSG and saturated to 16 bits with sticky clip flags.
module sid_audio_mixer
  import sid_audio_pkg::*;
#(
  parameter int DCB_SHIFT = DEF_DCB_SHIFT,
  parameter int FRAC      = DEF_FRAC
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ce_sample,
  input  logic [15:0]   sid_l,
  input  logic [15:0]   sid_r,
  input  logic signed [15:0] psg_l,
  input  logic signed [15:0] psg_r,
  input  logic [2:0]    sid_vol,
  input  logic          sid_en,
  input  logic          clip_clr,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic          out_valid,
  output logic          clip_l,
  output logic          clip_r
);

  sample_t    sid0_l, sid0_r, psg0_l, psg0_r, psg1_l, psg1_r;
  logic [2:0] vol0, vol1;
  logic       v0, v1, en0;
  logic signed [YI_W-1:0] yi_l, yi_r;
  acc_t       sum_l, sum_r;

  // Capture; MSB inversion turns offset-binary 0x8000 into signed 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v0     <= 1'b0;
      en0    <= 1'b0;
      vol0   <= '0;
      sid0_l <= '0;
      sid0_r <= '0;
      psg0_l <= '0;
      psg0_r <= '0;
    end else begin
      v0 <= ce_sample;
      if (ce_sample) begin
        en0    <= sid_en;
        vol0   <= sid_vol;
        sid0_l <= {~sid_l[15], sid_l[14:0]};
        sid0_r <= {~sid_r[15], sid_r[14:0]};
        psg0_l <= psg_l;
        psg0_r <= psg_r;
      end
    end
  end

  sid_dc_block #(.DCB_SHIFT(DCB_SHIFT), .FRAC(FRAC)) u_dc_l (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (v0 & en0),
    .clr     (~en0),
    .x       (sid0_l),
    .y_int   (yi_l)
  );

  sid_dc_block #(.DCB_SHIFT(DCB_SHIFT), .FRAC(FRAC)) u_dc_r (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (v0 & en0),
    .clr     (~en0),
    .x       (sid0_r),
    .y_int   (yi_r)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1     <= 1'b0;
      vol1   <= '0;
      psg1_l <= '0;
      psg1_r <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        vol1   <= vol0;
        psg1_l <= psg0_l;
        psg1_r <= psg0_r;
      end
    end
  end

  assign sum_l = mix(yi_l, vol1, psg1_l);
  assign sum_r = mix(yi_r, vol1, psg1_r);

  // Scale/add and saturation share the output register to keep a 3-clock latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      clip_l    <= 1'b0;
      clip_r    <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        out_l <= saturate(sum_l);
        out_r <= saturate(sum_r);
      end
      clip_l <= (v1 & is_clip(sum_l)) | (clip_l & ~clip_clr);
      clip_r <= (v1 & is_clip(sum_r)) | (clip_r & ~clip_clr);
    end
  end

endmodule

// File: tb/tb_sid_audio_mixer.sv
// Scoreboard bench for sid_audio_mixer: the driver pushes model results,
// a negedge monitor pops and compares on every out_valid.
module tb_sid_audio_mixer;

  localparam int DCB = 10;
  localparam int FR  = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_sample = 1'b0;
  logic [15:0] sid_l = 16'h8000, sid_r = 16'h8000;
  logic signed [15:0] psg_l = '0, psg_r = '0;
  logic [2:0]  sid_vol = 3'd7;
  logic        sid_en = 1'b1;
  logic        clip_clr = 1'b0;
  logic signed [15:0] out_l, out_r;
  logic        out_valid, clip_l, clip_r;

  sid_audio_mixer #(.DCB_SHIFT(DCB), .FRAC(FR)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ce_sample (ce_sample),
    .sid_l     (sid_l),
    .sid_r     (sid_r),
    .psg_l     (psg_l),
    .psg_r     (psg_r),
    .sid_vol   (sid_vol),
    .sid_en    (sid_en),
    .clip_clr  (clip_clr),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .clip_l    (clip_l),
    .clip_r    (clip_r)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    longint l;
    longint r;
    bit     cl;
    bit     cr;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  longint xp[2], yp[2];
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: DC blocker on x*2^FR, then floor-scale by (vol+1)/8, add psg, clamp.
  function automatic longint model(input int ch, input logic [15:0] sid,
                                   input logic signed [15:0] psg,
                                   input logic [2:0] v, input logic en,
                                   output bit clipped);
    longint x, y, s;
    if (!en) begin
      xp[ch] = 0;
      yp[ch] = 0;
      y = 0;
    end else begin
      x = (longint'(sid) - 32768) * (longint'(1) << FR);
      y = x - xp[ch] + yp[ch] - (yp[ch] >>> DCB);
      xp[ch] = x;
      yp[ch] = y;
    end
    s = (((y >>> FR) * (longint'(v) + 1)) >>> 3) + longint'(psg);
    clipped = (s > 32767) || (s < -32768);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic send(input logic [15:0] sl, input logic [15:0] sr,
                      input logic signed [15:0] pl, input logic signed [15:0] pr,
                      input logic [2:0] v, input logic en);
    exp_t e;
    sid_l = sl; sid_r = sr; psg_l = pl; psg_r = pr; sid_vol = v; sid_en = en;
    ce_sample = 1'b1;
    e.l = model(0, sl, pl, v, en, e.cl);
    e.r = model(1, sr, pr, v, en, e.cr);
    e.cyc = cyc + 3;
    sb.push_back(e);
    @(posedge clock); #1;
    ce_sample = 1'b0;
    sid_l = 16'($urandom); sid_r = 16'($urandom);
    psg_l = 16'($urandom); psg_r = 16'($urandom);
    sid_vol = 3'($urandom); sid_en = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    xp[0] = 0; xp[1] = 0; yp[0] = 0; yp[1] = 0;
    #2;
    chk("rst_out_l", out_l, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_clip_l", clip_l, 0);
    chk("rst_clip_r", clip_r, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  // Monitor with its own sticky-flag model: a clip wins over a pending clear.
  initial begin
    exp_t   e;
    bit     fl = 0, fr = 0, pend = 0, hl, hr;
    longint last_l = 0, last_r = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        fl = 0; fr = 0; pend = 0; last_l = 0; last_r = 0;
        continue;
      end
      hl = 0; hr = 0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("out_l", out_l, e.l);
          chk("out_r", out_r, e.r);
          chk("latency", cyc, e.cyc);
          hl = e.cl; hr = e.cr;
          last_l = e.l; last_r = e.r;
        end
      end else begin
        chk("hold_l", out_l, last_l);
        chk("hold_r", out_r, last_r);
      end
      if (hl) fl = 1; else if (pend) fl = 0;
      if (hr) fr = 1; else if (pend) fr = 0;
      chk("clip_l", clip_l, fl);
      chk("clip_r", clip_r, fr);
      pend = clip_clr;
    end
  end

  initial begin
    int w;
    idle(1);
    chk("init_out_l", out_l, 0);
    chk("init_valid", out_valid, 0);
    chk("init_clip_l", clip_l, 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Midpoint SID, silent PSG, repeated strobes
    for (int i = 0; i < 6; i++) begin
      send(16'h8000, 16'h8000, 16'sd0, 16'sd0, 3'd7, 1'b1);
      idle(i % 3);
    end
    idle(4);

    // SID step, then decay
    for (int i = 0; i < 10; i++) begin
      send(16'hC000, 16'h4000, 16'sd0, 16'sd0, 3'd7, 1'b1);
      idle(1);
    end

    // Clip on left, sticky until clip_clr
    send(16'h8000, 16'h8000, 16'sd0, 16'sd0, 3'd7, 1'b0);
    send(16'hC000, 16'h8000, 16'sd30000, 16'sd0, 3'd7, 1'b1);
    idle(5);
    clip_clr = 1'b1;
    idle(1);
    clip_clr = 1'b0;
    idle(4);

    // Clear coinciding with a clipping sample: flag must stay set
    send(16'h8000, 16'h8000, 16'sd0, 16'sd0, 3'd7, 1'b0);
    send(16'hC000, 16'h8000, 16'sd30000, -16'sd30000, 3'd7, 1'b1);
    idle(1);
    clip_clr = 1'b1;
    idle(1);
    clip_clr = 1'b0;
    idle(3);
    clip_clr = 1'b1;
    idle(1);
    clip_clr = 1'b0;
    idle(3);

    // Reduced volume, then SID disabled
    send(16'h8000, 16'h8000, 16'sd0, 16'sd0, 3'd3, 1'b0);
    send(16'hC000, 16'hC000, 16'sd0, 16'sd0, 3'd3, 1'b1);
    send(16'hC000, 16'h1234, 16'sd0, 16'sd0, 3'd3, 1'b1);
    for (int i = 0; i < 5; i++)
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'd7, 1'b0);
    idle(4);

    // Back-to-back ramp with a reset in the middle
    for (int i = 0; i < 24; i++) begin
      if (i == 12) do_reset();
      send(16'(16'h7000 + i * 16'h0200), 16'(16'h9000 - i * 16'h0100),
           16'(i * 300), 16'(-i * 200), 3'(i), 1'b1);
    end
    idle(5);

    // Randomised traffic with random gaps and clears
    for (int i = 0; i < 400; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           3'($urandom), ($urandom_range(0, 9) != 0));
      w = $urandom_range(0, 2);
      for (int k = 0; k < w; k++) begin
        clip_clr = ($urandom_range(0, 5) == 0);
        idle(1);
        clip_clr = 1'b0;
      end
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
    chk("drain", sb.size(), 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sid_audio_mixer.md
SID_AUDIO_MIXER -- requirements
Module: sid_audio_mixer

Interface
REQ-001 SHALL have parameter DCB_SHIFT, default 10, DC-blocker pole shift; leak = y>>>DCB_SHIFT.
REQ-002 SHALL have parameter FRAC, default 8, fractional bits of internal filter state.
REQ-003 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ce_sample, input, 1, one-cycle sample strobe.
REQ-006 SHALL have ports sid_l and sid_r, input, 16, SID outputs, unsigned offset-binary with midpoint 0x8000.
REQ-007 SHALL have ports psg_l and psg_r, input, 16, signed PSG audio.
REQ-008 SHALL have port sid_vol, input, 3, SID gain = (sid_vol+1)/8.
REQ-009 SHALL have port sid_en, input, 1; 0 mutes SID and holds filter state at zero.
REQ-010 SHALL have port clip_clr, input, 1, clears sticky clip flags.
REQ-011 SHALL have ports out_l and out_r, output, 16, signed mixed audio.
REQ-012 SHALL have port out_valid, output, 1, one-cycle strobe marking new out_l/out_r.
REQ-013 SHALL have ports clip_l and clip_r, output, 1, sticky saturation flags.

Function
REQ-014 Stage 0 SHALL, on ce_sample, capture all sid/psg/vol inputs and convert sid to signed via MSB inversion (0x8000 -> 0).
REQ-015 Stage 1 SHALL run the DC blocker per channel at FRAC-extended width (16+FRAC+2 bits): y = x - x_prev + y_prev - (y_prev >>> DCB_SHIFT); update x_prev and y_prev.
REQ-016 Stage 2 SHALL take y >>> FRAC, multiply by (sid_vol+1), arithmetic-shift right by 3, and add the sign-extended psg sample in 19 bits.
REQ-017 Stage 3 SHALL saturate the sum to [-32768, +32767], register out_l/out_r, and pulse out_valid.
REQ-018 Latency SHALL be exactly 3 clocks from ce_sample to out_valid; a ce_sample on every clock is accepted (fully pipelined, no stall).
REQ-019 out_l/out_r SHALL hold their value between out_valid pulses.
REQ-020 With sid_en=0 the SID contribution SHALL be 0 and x_prev/y_prev SHALL be forced to 0; output equals psg.
REQ-021 clip_l/clip_r SHALL set on any saturated sample and clear on clip_clr; saturation in the same cycle as clip_clr SHALL win (flag stays 1).
REQ-022 Arithmetic SHALL never wrap internally; every intermediate is sized for the worst case.

Reset
REQ-023 reset_n low SHALL asynchronously clear out_l, out_r, out_valid, clip_l, clip_r, all pipeline registers and x_prev/y_prev to 0.
REQ-024 Reset mid-pipeline SHALL drop in-flight samples; the first out_valid after release comes 3 clocks after the first post-reset ce_sample.

Structure
REQ-025 A shared package sid_audio_pkg SHALL hold sample width (16), accumulator width, saturation limits and the default DCB_SHIFT/FRAC constants.
REQ-026 The DC blocker SHALL be a sub-module sid_dc_block (one channel, enable + clear), instantiated twice.

Verification
REQ-027 sid=0x8000, psg=0, vol=7, repeated strobes -> out=0, out_valid exactly 3 clocks after each strobe.
REQ-028 Step sid_l 0x8000->0xC000, vol=7 -> first output +16384, then monotonically decaying toward 0.
REQ-029 psg_l=+30000 plus sid step +16384, vol=7 -> out_l=32767, clip_l=1 until clip_clr; clip_clr in same cycle as a clip -> clip_l remains 1.
REQ-030 vol=3, sid step +16384 -> first output +8192; sid_en=0 -> output equals psg_l exactly, filter state 0.
REQ-031 Back-to-back ce_sample each clock with ramp inputs -> one out_valid per strobe, order preserved; reset_n pulse mid-stream -> all outputs 0, no stale out_valid.
